// File: rtl/game_pkg.sv
// game_pkg: shared slot counts, position field layout, hit-box geometry and scanner FSM states.
package game_pkg;
  localparam int DEF_MAX_ENEMY = 15;
  localparam int DEF_MAX_ENEMY_BULLET = 31;
  localparam int DEF_MAX_PLAYER_BULLET = 15;
  localparam int DEF_HIT_W = 16;
  localparam int DEF_HIT_H = 16;
  localparam int DEF_PLAYER_Y = 440;
  localparam int POS_W = 19;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int X_LSB = 9;
  localparam int Y_LSB = 0;
  typedef enum logic [1:0] {IDLE, SCAN_PB, SCAN_EB, DONE} state_e;
endpackage

// File: rtl/hit_test.sv
// hit_test: combinational box overlap of two {x,y} points using 11-bit signed differences.
module hit_test import game_pkg::*; #(
  parameter int HIT_W = DEF_HIT_W,
  parameter int HIT_H = DEF_HIT_H
) (
  input  logic [POS_W-1:0] a_i,
  input  logic [POS_W-1:0] b_i,
  output logic             hit_o
);
  logic signed [10:0] dx, dy;
  logic [10:0] ax, ay;
  always_comb begin
    dx = $signed({1'b0, a_i[X_LSB +: X_W]}) - $signed({1'b0, b_i[X_LSB +: X_W]});
    dy = $signed({2'b0, a_i[Y_LSB +: Y_W]}) - $signed({2'b0, b_i[Y_LSB +: Y_W]});
    ax = dx[10] ? -dx : dx;
    ay = dy[10] ? -dy : dy;
    hit_o = (ax < 11'(HIT_W)) && (ay < 11'(HIT_H));
  end
endmodule

// File: rtl/collision_scanner.sv
// collision_scanner: per-frame sequential collision scan, one pair per cycle through a shared hit_test.
// Optional enemy kill counter enabled by defining COLLISION_KILL_COUNT_EN.
module collision_scanner import game_pkg::*; #(
  parameter int MAX_ENEMY         = DEF_MAX_ENEMY,
  parameter int MAX_ENEMY_BULLET  = DEF_MAX_ENEMY_BULLET,
  parameter int MAX_PLAYER_BULLET = DEF_MAX_PLAYER_BULLET,
  parameter int HIT_W             = DEF_HIT_W,
  parameter int HIT_H             = DEF_HIT_H,
  parameter int PLAYER_Y          = DEF_PLAYER_Y
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic                                i_Start,
  input  logic [MAX_ENEMY-1:0]                i_EnemyState,
  input  logic [MAX_ENEMY_BULLET-1:0]         i_EnemyBulletState,
  input  logic [MAX_PLAYER_BULLET-1:0]        i_PlayerBulletState,
  input  logic                                i_PlayerState,
  input  logic [POS_W*MAX_ENEMY-1:0]          i_EnemyPosition,
  input  logic [POS_W*MAX_ENEMY_BULLET-1:0]   i_EnemyBulletPosition,
  input  logic [POS_W*MAX_PLAYER_BULLET-1:0]  i_PlayerBulletPosition,
  input  logic [X_W-1:0]                      i_PlayerPosition,
  output logic [MAX_ENEMY-1:0]                o_EnemyHit,
  output logic [MAX_ENEMY_BULLET-1:0]         o_EnemyBulletHit,
  output logic [MAX_PLAYER_BULLET-1:0]        o_PlayerBulletHit,
  output logic                                o_PlayerHit,
  output logic                                o_Busy,
  output logic                                o_Done,
  output logic [7:0]                          o_KillCount
);
  localparam int PW = $clog2(MAX_PLAYER_BULLET + 1);
  localparam int EW = $clog2(MAX_ENEMY + 1);
  localparam int BW = $clog2(MAX_ENEMY_BULLET + 1);
  localparam logic [PW-1:0] P_LAST = PW'(MAX_PLAYER_BULLET - 1);
  localparam logic [EW-1:0] E_LAST = EW'(MAX_ENEMY - 1);
  localparam logic [BW-1:0] B_LAST = BW'(MAX_ENEMY_BULLET - 1);
  state_e state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [EW-1:0] e_q, e_d;
  logic [BW-1:0] b_q, b_d;
  logic [MAX_ENEMY-1:0] en_act_q, en_act_d, enh_q, enh_d;
  logic [MAX_ENEMY_BULLET-1:0] eb_act_q, eb_act_d, ebh_q, ebh_d;
  logic [MAX_PLAYER_BULLET-1:0] pb_act_q, pb_act_d, pbh_q, pbh_d;
  logic pl_act_q, pl_act_d, plh_q, plh_d;
  logic [POS_W-1:0] a_pos, b_pos;
  logic hit, pb_hit, eb_hit;
  hit_test #(.HIT_W(HIT_W), .HIT_H(HIT_H)) u_hit (.a_i(a_pos), .b_i(b_pos), .hit_o(hit));
  always_comb begin
    a_pos = (state_q == SCAN_EB) ? i_EnemyBulletPosition[POS_W*b_q +: POS_W]
                                 : i_PlayerBulletPosition[POS_W*p_q +: POS_W];
    b_pos = (state_q == SCAN_EB) ? {i_PlayerPosition, Y_W'(PLAYER_Y)}
                                 : i_EnemyPosition[POS_W*e_q +: POS_W];
    // a bullet or enemy already consumed this scan cannot score again
    pb_hit = (state_q == SCAN_PB) && pb_act_q[p_q] && en_act_q[e_q] && !pbh_q[p_q] && !enh_q[e_q] && hit;
    eb_hit = (state_q == SCAN_EB) && eb_act_q[b_q] && pl_act_q && hit;
  end
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    e_d = e_q;
    b_d = b_q;
    en_act_d = en_act_q;
    eb_act_d = eb_act_q;
    pb_act_d = pb_act_q;
    pl_act_d = pl_act_q;
    enh_d = enh_q;
    ebh_d = ebh_q;
    pbh_d = pbh_q;
    plh_d = plh_q;
    case (state_q)
      IDLE: if (i_Start) begin
        en_act_d = i_EnemyState;
        eb_act_d = i_EnemyBulletState;
        pb_act_d = i_PlayerBulletState;
        pl_act_d = i_PlayerState;
        enh_d = '0;
        ebh_d = '0;
        pbh_d = '0;
        plh_d = 1'b0;
        p_d = '0;
        e_d = '0;
        b_d = '0;
        state_d = SCAN_PB;
      end
      SCAN_PB: begin
        if (pb_hit) begin
          pbh_d[p_q] = 1'b1;
          enh_d[e_q] = 1'b1;
        end
        e_d = (e_q == E_LAST) ? '0 : e_q + 1'b1;
        p_d = (e_q == E_LAST && p_q != P_LAST) ? p_q + 1'b1 : p_q;
        b_d = '0;
        state_d = (e_q == E_LAST && p_q == P_LAST) ? SCAN_EB : SCAN_PB;
      end
      SCAN_EB: begin
        if (eb_hit) begin
          ebh_d[b_q] = 1'b1;
          plh_d = 1'b1;
        end
        b_d = (b_q == B_LAST) ? b_q : b_q + 1'b1;
        state_d = (b_q == B_LAST) ? DONE : SCAN_EB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      p_q <= '0;
      e_q <= '0;
      b_q <= '0;
      en_act_q <= '0;
      eb_act_q <= '0;
      pb_act_q <= '0;
      pl_act_q <= 1'b0;
      enh_q <= '0;
      ebh_q <= '0;
      pbh_q <= '0;
      plh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      e_q <= e_d;
      b_q <= b_d;
      en_act_q <= en_act_d;
      eb_act_q <= eb_act_d;
      pb_act_q <= pb_act_d;
      pl_act_q <= pl_act_d;
      enh_q <= enh_d;
      ebh_q <= ebh_d;
      pbh_q <= pbh_d;
      plh_q <= plh_d;
    end
  end
  assign o_EnemyHit = enh_q;
  assign o_EnemyBulletHit = ebh_q;
  assign o_PlayerBulletHit = pbh_q;
  assign o_PlayerHit = plh_q;
  assign o_Busy = (state_q != IDLE);
  assign o_Done = (state_q == DONE);
`ifdef COLLISION_KILL_COUNT_EN
  logic [7:0] kill_q, kill_d;
  assign kill_d = (pb_hit && kill_q != 8'hff) ? kill_q + 8'd1 : kill_q;
  always_ff @(posedge i_Clk) kill_q <= i_Rst ? 8'd0 : kill_d;
  assign o_KillCount = kill_q;
`else
  assign o_KillCount = 8'd0;
`endif
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed scans with a queue of expected hit masks popped at each o_Done.
module tb_collision_scanner;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [14:0] en_st, en_hit, pb_st, pb_hit;
  logic [30:0] eb_st, eb_hit;
  logic pl_st, pl_hit, busy, done;
  logic [19*15-1:0] en_pos, pb_pos;
  logic [19*31-1:0] eb_pos;
  logic [9:0] pl_x;
  logic [7:0] kills;
  typedef struct {logic [14:0] en; logic [30:0] eb; logic [14:0] pb; logic ph;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int tests = 0, fails = 0;

  collision_scanner dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start),
    .i_EnemyState(en_st), .i_EnemyBulletState(eb_st), .i_PlayerBulletState(pb_st),
    .i_PlayerState(pl_st),
    .i_EnemyPosition(en_pos), .i_EnemyBulletPosition(eb_pos), .i_PlayerBulletPosition(pb_pos),
    .i_PlayerPosition(pl_x),
    .o_EnemyHit(en_hit), .o_EnemyBulletHit(eb_hit), .o_PlayerBulletHit(pb_hit),
    .o_PlayerHit(pl_hit), .o_Busy(busy), .o_Done(done), .o_KillCount(kills)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    en_st = '0; eb_st = '0; pb_st = '0; pl_st = 1'b0;
    en_pos = '0; eb_pos = '0; pb_pos = '0; pl_x = '0;
  endtask

  task automatic push(input logic [14:0] en, input logic [30:0] eb, input logic [14:0] pb, input logic ph);
    exp_t x;
    x.en = en; x.eb = eb; x.pb = pb; x.ph = ph;
    sb.push_back(x);
  endtask

  // cycle 0 is the one in which start is driven; done must show in cycle 257
  task automatic do_scan(input string tag, input bit mid_start);
    int n;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      start = (mid_start && n == 50);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, n, 257);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check({tag, "_en"}, 32'(en_hit), 32'(cur.en));
      check({tag, "_eb"}, 32'(eb_hit), 32'(cur.eb));
      check({tag, "_pb"}, 32'(pb_hit), 32'(cur.pb));
      check({tag, "_ph"}, 32'(pl_hit), 32'(cur.ph));
    end
  endtask

  initial begin
    int n, seen, nscan, kexp;
    clr();
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_en", 32'(en_hit), 32'd0);
    check("rst_ph", 32'(pl_hit), 32'd0);
    check("rst_kills", 32'(kills), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    pb_st[0] = 1'b1; pb_pos[0 +: 19] = {10'd100, 9'd200};
    en_st[3] = 1'b1; en_pos[19*3 +: 19] = {10'd110, 9'd205};
    push(15'h0008, '0, 15'h0001, 1'b0);
    do_scan("basic", 1'b0);
    repeat (5) @(negedge clk);
    check("hold_en", 32'(en_hit), 32'h8);
    check("hold_pb", 32'(pb_hit), 32'h1);
    check("hold_busy", 32'(busy), 32'd0);

    pb_st[1] = 1'b1; pb_pos[19 +: 19] = {10'd100, 9'd200};
    push(15'h0008, '0, 15'h0001, 1'b0);
    do_scan("two_bullets", 1'b1);

    clr();
    pb_st[0] = 1'b1; pb_pos[0 +: 19] = {10'd100, 9'd200};
    en_st[3] = 1'b1; en_pos[19*3 +: 19] = {10'd116, 9'd200};
    push('0, '0, '0, 1'b0);
    do_scan("dx16", 1'b0);
    en_pos[19*3 +: 19] = {10'd115, 9'd200};
    push(15'h0008, '0, 15'h0001, 1'b0);
    do_scan("dx15", 1'b0);
    en_pos[19*3 +: 19] = {10'd84, 9'd216};
    push('0, '0, '0, 1'b0);
    do_scan("dneg", 1'b0);
    en_pos[19*3 +: 19] = {10'd85, 9'd185};
    push(15'h0008, '0, 15'h0001, 1'b0);
    do_scan("dneg_in", 1'b0);

    clr();
    eb_st[5] = 1'b1; eb_pos[19*5 +: 19] = {10'd300, 9'd445}; pl_x = 10'd305; pl_st = 1'b1;
    push('0, 31'h20, '0, 1'b1);
    do_scan("eb_hit", 1'b0);
    pl_st = 1'b0;
    push('0, '0, '0, 1'b0);
    do_scan("eb_dead", 1'b0);

    clr();
    pb_st[0] = 1'b1; pb_pos[0 +: 19] = {10'd100, 9'd200};
    en_st[3] = 1'b1; en_pos[19*3 +: 19] = {10'd110, 9'd205};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (n < 100) begin @(negedge clk); n++; end
    check("mid_en_set", 32'(en_hit), 32'h8);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_en", 32'(en_hit), 32'd0);
    check("abort_pb", 32'(pb_hit), 32'd0);
    check("abort_kills", 32'(kills), 32'd0);
    seen = 0;
    repeat (300) begin @(negedge clk); seen += int'(done); end
    check("abort_no_done", seen, 0);

    clr();
    for (int k = 0; k < 3; k++) begin
      pb_st[k] = 1'b1; pb_pos[19*k +: 19] = {10'(100 + 40*k), 9'd100};
      en_st[k] = 1'b1; en_pos[19*k +: 19] = {10'(100 + 40*k), 9'd100};
    end
`ifdef COLLISION_KILL_COUNT_EN
    nscan = 90; kexp = 255;
`else
    nscan = 2; kexp = 0;
`endif
    for (int s = 0; s < nscan; s++) begin
      push(15'h7, '0, 15'h7, 1'b0);
      do_scan("kill", 1'b0);
    end
    check("kill_count", 32'(kills), 32'(kexp));
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/collision_scanner.md
COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameter MAX_ENEMY, default 15: number of enemy slots.
REQ-002 Parameter MAX_ENEMY_BULLET, default 31: number of enemy-bullet slots.
REQ-003 Parameter MAX_PLAYER_BULLET, default 15: number of player-bullet slots.
REQ-004 Parameters HIT_W / HIT_H, default 16 / 16: half-extents of the hit box in pixels; PLAYER_Y, default 440: fixed player row.
REQ-005 i_Clk  input  1  sole clock; all logic on rising edge.
REQ-006 i_Rst  input  1  synchronous, active-high reset.
REQ-007 i_Start  input  1  one-cycle pulse (frame tick) that begins a scan.
REQ-008 i_EnemyState / i_EnemyBulletState / i_PlayerBulletState  input  MAX_ENEMY / MAX_ENEMY_BULLET / MAX_PLAYER_BULLET  per-slot active bits.
REQ-009 i_PlayerState  input  1  player alive.
REQ-010 i_EnemyPosition / i_EnemyBulletPosition / i_PlayerBulletPosition  input  19*N flat  per slot {x[18:9], y[8:0]}; slot k at bits [19k+18:19k].
REQ-011 i_PlayerPosition  input  10  player x.
REQ-012 o_EnemyHit / o_EnemyBulletHit / o_PlayerBulletHit  output  same widths as REQ-008  per-slot hit masks of the last scan.
REQ-013 o_PlayerHit  output  1  player hit in last scan.
REQ-014 o_Busy  output  1  scan in progress; o_Done  output  1  one-cycle pulse at scan end.
REQ-015 o_KillCount  output  8  enemy kills since reset (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, SCAN_PB, SCAN_EB, DONE.
REQ-017 In IDLE, i_Start SHALL latch all state inputs into internal masks, clear all hit masks, and enter SCAN_PB with counters p=0, e=0.
REQ-018 SCAN_PB SHALL test exactly one (player bullet p, enemy e) pair per cycle, e innermost, then advance; after p=MAX_PLAYER_BULLET-1, e=MAX_ENEMY-1 it SHALL enter SCAN_EB with b=0.
REQ-019 SCAN_EB SHALL test enemy bullet b against the player (x=i_PlayerPosition, y=PLAYER_Y) once per cycle; after b=MAX_ENEMY_BULLET-1 it SHALL enter DONE.
REQ-020 DONE SHALL last one cycle, assert o_Done, and return to IDLE.
REQ-021 A hit SHALL require |dx| < HIT_W and |dy| < HIT_H, computed as 11-bit signed differences with no wrap-around.
REQ-022 A pair SHALL be skipped (no hit) if either slot is inactive in the latched mask, or already marked hit in this scan; each bullet kills at most one enemy and each enemy takes at most one bullet.
REQ-023 An enemy-bullet test SHALL be skipped if the latched player bit is 0; multiple bullets may set their own hit bits, o_PlayerHit is the OR.
REQ-024 o_Busy SHALL be 1 from the cycle after i_Start through DONE inclusive; i_Start while o_Busy=1 SHALL be ignored.
REQ-025 With defaults, i_Start at cycle 0 SHALL yield o_Done at cycle 257 (225+31 test cycles + 1).
REQ-026 Hit masks SHALL hold their values from DONE until the next accepted i_Start.
REQ-027 Positions are read live; the caller holds them stable while o_Busy=1.

Reset
REQ-028 i_Rst SHALL force IDLE, all masks/counters 0, o_Busy=0, o_Done=0, o_PlayerHit=0, o_KillCount=0.
REQ-029 i_Rst mid-scan SHALL abort with no o_Done; i_Rst with i_Start in the same cycle SHALL take reset.

Configuration
REQ-030 With COLLISION_KILL_COUNT_EN defined, o_KillCount SHALL increment by 1 per enemy hit, saturating at 255.
REQ-031 Without COLLISION_KILL_COUNT_EN, o_KillCount SHALL be constant 0 and no counter logic is built.

Structure
REQ-032 Package game_pkg SHALL hold MAX_* defaults, position field widths/offsets, HIT_W/HIT_H/PLAYER_Y, and the FSM state enum.
REQ-033 Sub-module hit_test (combinational box-overlap of two {x,y} points) SHALL be instantiated once and shared by both scan states.

Verification
REQ-034 Bullet 0 at (100,200), enemy 3 at (110,205), both active; scan -> o_EnemyHit=0x0008, o_PlayerBulletHit=0x0001, o_Done at cycle 257.
REQ-035 Bullets 0 and 1 both overlapping enemy 3 -> only bullet 0 bit set, o_EnemyHit=0x0008.
REQ-036 |dx|=16 exactly (bullet x=100, enemy x=116) -> no hit; x=115 -> hit.
REQ-037 Enemy bullet 5 at (300,445), player x=305, i_PlayerState=1 -> o_EnemyBulletHit bit 5 and o_PlayerHit=1; i_PlayerState=0 -> both 0.
REQ-038 i_Rst at cycle 100 of a scan -> no o_Done, o_Busy=0 and masks 0 next cycle; i_Start during scan ignored.
REQ-039 COLLISION_KILL_COUNT_EN defined, 3 kills per scan for 90 scans -> o_KillCount=255; undefined -> 0.
